// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder
//  Purpose  : WIDTH-bit adder that time-shares one external 4-bit adder slice,
//             one nibble per cycle, with a registered carry between steps.
//  Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_s,
   input  logic             add_cout
);

   localparam int N    = WIDTH / 4;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] C_LAST = IDXW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_sum;
   logic              r_carry;
   logic              r_cout;
   logic              r_ovf;
   logic [IDXW-1:0]   r_idx;
   logic              w_accept;
   logic              w_last;

   assign w_accept = (r_state == IDLE) && start;
   assign w_last   = (r_state == ADD) && (r_idx == C_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = ADD;
         ADD:     if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // The final nibble's add_s[3] is the result MSB, so overflow is decided
   // from the slice output rather than from the not-yet-written r_sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a     <= op_a;
         r_b     <= op_b;
         r_carry <= cin;
         r_idx   <= '0;
      end else if (r_state == ADD) begin
         for (int n = 0; n < N; n++) begin
            if (r_idx == IDXW'(n)) begin
               r_sum[4*n +: 4] <= add_s;
            end
         end
         r_carry <= add_cout;
         r_idx   <= r_idx + 1'b1;
         if (w_last) begin
            r_cout <= add_cout;
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (add_s[3] != r_a[WIDTH-1]);
         end
      end
   end

   always_comb begin
      add_a   = 4'd0;
      add_b   = 4'd0;
      add_cin = 1'b0;
      if (r_state == ADD) begin
         add_cin = r_carry;
         for (int n = 0; n < N; n++) begin
            if (r_idx == IDXW'(n)) begin
               add_a = r_a[4*n +: 4];
               add_b = r_b[4*n +: 4];
            end
         end
      end
   end

   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE);
   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder controller that time-multiplexes a single external 4-bit ripple-carry adder slice. It is the stage directly around the 4-bit adder: it feeds one operand nibble pair plus carry-in per cycle and consumes the nibble sum and carry-out. It registers the carry between cycles and assembles the full-width result. It sits between the operand/issue logic and the 4-bit adder, and gives wide additions one small adder at the cost of WIDTH/4 cycles.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8
N (localparam), WIDTH/4, number of nibble steps

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op_a  input  WIDTH  operand A, captured when start is accepted
op_b  input  WIDTH  operand B, captured when start is accepted
cin  input  1  carry-in to nibble 0, captured with the operands
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  registered result, held until next accepted start
cout  output  1  carry-out of bit WIDTH-1, registered
ovf  output  1  two's-complement overflow, registered
add_a  output  4  nibble of A driven to the adder slice
add_b  output  4  nibble of B driven to the adder slice
add_cin  output  1  carry driven to the adder slice
add_s  input  4  nibble sum returned by the adder slice (combinational)
add_cout  input  1  carry-out returned by the adder slice (combinational)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, carry=0, a_reg=b_reg=0, sum=0, cout=0, ovf=0, busy=0, done=0. Output pins add_a/add_b/add_cin read 0. Reset mid-operation abandons the operation with no done pulse.
- FSM states: IDLE, ADD, DONE.
- IDLE: if start=1 at a rising edge, latch a_reg=op_a, b_reg=op_b, carry=cin, idx=0, and go to ADD. Otherwise stay in IDLE. add_a/add_b/add_cin are driven as 0.
- ADD: add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry, all combinational from registers. At each edge:
  - sum[4*idx+:4] <= add_s
  - carry <= add_cout
  - idx <= idx+1
  - when idx==N-1, also cout <= add_cout, compute ovf, and go to DONE.
- Overflow rule: ovf = (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (final sum[WIDTH-1] != a_reg[WIDTH-1]). The final-nibble add_s[3] is used as the sum MSB.
- DONE: done=1 for exactly this one cycle, then unconditionally go to IDLE. start is ignored in DONE.
- Latency: start high in cycle 0 gives ADD in cycles 1..N and done high in cycle N+1 (cycle 5 for WIDTH=16). Back-to-back throughput is one op per N+2 cycles.
- start while busy=1 is ignored. op_a/op_b/cin may change freely after acceptance without affecting the result.
- sum/cout/ovf are undefined-but-stable during ADD, because nibbles update progressively. They are valid from the done cycle until the next accepted start.
- Width arithmetic: WIDTH+1-bit result = {cout,sum} = op_a + op_b + cin (unsigned, modulo 2^(WIDTH+1)).
- The adder slice is purely combinational. No registers are permitted on the add_* path inside this block.

Test Plan:
- Bench instantiates the 4-bit ripple-carry adder wired to add_*. Reset, then start with A=0x1234, B=0x4321, cin=0 -> done in cycle 5, sum=0x5555, cout=0, ovf=0, busy high in cycles 1-5.
- A=0xFFFF, B=0x0001, cin=0 -> carry ripples across all 4 nibbles, sum=0x0000, cout=1, ovf=0.
- A=0x7FFF, B=0x0001 -> sum=0x8000, cout=0, ovf=1. A=0x8000, B=0x8000 -> sum=0x0000, cout=1, ovf=1.
- A=0x00FF, B=0x0000, cin=1 -> sum=0x0100, cout=0. Check cin is captured: drop cin to 0 in cycle 1 and the result is unchanged.
- Start accepted with A=0x0001, B=0x0001; pulse start again with A=0xAAAA in cycle 2 and in the DONE cycle -> both ignored, sum=0x0002, exactly one done pulse. A new start in cycle 6 is accepted.
- Assert rst_n low in cycle 3 of an op -> busy/done/sum/cout/ovf/add_* go to 0 immediately with no done pulse. After release, a fresh 0x0F0F+0xF0F0 -> 0xFFFF, cout=0.
